// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the fetch frontend: exception codes, fetch FSM states
// and the registered output bundle handed to decode.
package instruction_fetch_pkg;

   localparam int EXCEPTION_LEN = 4;

   localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                 = 4'd0;
   localparam logic [EXCEPTION_LEN-1:0] EXCEP_INSTR_MISALIGNED   = 4'd1;
   localparam logic [EXCEPTION_LEN-1:0] EXCEP_INSTR_ACCESS_FAULT = 4'd2;

   typedef enum logic [2:0] {
      FETCH_STATE_REQ  = 3'd0,
      FETCH_STATE_WAIT = 3'd1,
      FETCH_STATE_HOLD = 3'd2,
      FETCH_STATE_DROP = 3'd3,
      FETCH_STATE_HALT = 3'd4
   } fetch_state_e;

   typedef struct packed {
      logic [31:0]              instr;
      logic [31:0]              pc;
      logic [EXCEPTION_LEN-1:0] exc;
   } fetch_out_t;

   // Sequential PC; wraps naturally at 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch unit: single-outstanding word reads from instruction memory, one
// instruction (or fetch exception) presented to decode under valid/ready.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk_In,
   input  logic                     reset_In,
   output logic                     memReq_Out,
   output logic [31:0]              memAddr_Out,
   input  logic                     memGrant_In,
   input  logic                     memValid_In,
   input  logic [31:0]              memData_In,
   input  logic                     memError_In,
   output logic                     instrValid_Out,
   input  logic                     instrReady_In,
   output logic [31:0]              instr_Out,
   output logic [31:0]              pc_Out,
   input  logic                     redirectValid_In,
   input  logic [31:0]              redirectPc_In,
   output logic [EXCEPTION_LEN-1:0] exception_Out
);

   fetch_state_e r_state;
   logic [31:0]  r_fetchPc;
   fetch_out_t   r_out;

   logic w_aligned;
   logic w_memReq;
   logic w_granted;

   assign w_aligned = (r_fetchPc[1:0] == 2'b00);
   // Gated by reset so nothing is requested while the unit is being cleared.
   assign w_memReq  = (r_state == FETCH_STATE_REQ) && w_aligned && !reset_In;
   assign w_granted = w_memReq && memGrant_In;

   always_ff @(posedge clk_In) begin
      if (reset_In) begin
         r_state   <= FETCH_STATE_REQ;
         r_fetchPc <= RESET_PC;
         r_out     <= '{instr: 32'h0, pc: RESET_PC, exc: EXCEP_OK};
      end else if (redirectValid_In) begin
         // A granted or unanswered request must still be drained in DROP.
         r_fetchPc <= redirectPc_In;
         case (r_state)
            FETCH_STATE_REQ:  r_state <= w_granted ? FETCH_STATE_DROP : FETCH_STATE_REQ;
            FETCH_STATE_WAIT,
            FETCH_STATE_DROP: r_state <= memValid_In ? FETCH_STATE_REQ : FETCH_STATE_DROP;
            default:          r_state <= FETCH_STATE_REQ;
         endcase
      end else begin
         case (r_state)
            FETCH_STATE_REQ: begin
               if (!w_aligned) begin
                  r_state <= FETCH_STATE_HOLD;
                  r_out   <= '{instr: 32'h0, pc: r_fetchPc, exc: EXCEP_INSTR_MISALIGNED};
               end else if (w_granted) begin
                  r_state <= FETCH_STATE_WAIT;
               end
            end
            FETCH_STATE_WAIT: begin
               if (memValid_In) begin
                  r_state <= FETCH_STATE_HOLD;
                  if (memError_In)
                     r_out <= '{instr: 32'h0, pc: r_fetchPc, exc: EXCEP_INSTR_ACCESS_FAULT};
                  else
                     r_out <= '{instr: memData_In, pc: r_fetchPc, exc: EXCEP_OK};
               end
            end
            FETCH_STATE_HOLD: begin
               if (instrReady_In) begin
                  if (r_out.exc == EXCEP_OK) begin
                     r_state   <= FETCH_STATE_REQ;
                     r_fetchPc <= pc_next(r_fetchPc);
                  end else begin
                     r_state <= FETCH_STATE_HALT;
                  end
               end
            end
            FETCH_STATE_DROP: begin
               if (memValid_In)
                  r_state <= FETCH_STATE_REQ;
            end
            FETCH_STATE_HALT: r_state <= FETCH_STATE_HALT;
            default:          r_state <= FETCH_STATE_REQ;
         endcase
      end
   end

   assign memReq_Out     = w_memReq;
   assign memAddr_Out    = r_fetchPc;
   assign instrValid_Out = (r_state == FETCH_STATE_HOLD);
   assign instr_Out      = r_out.instr;
   assign pc_Out         = r_out.pc;
   assign exception_Out  = r_out.exc;

endmodule
